calc_core: RTL
==============

# calc_core

Parametrised four-function calculator engine with a history stack. It sits between the keypad decoder and the seven-segment display driver. It accepts decimal operand entry and operator keys, and computes unsigned add/sub/mul/div/mod at width W. Division uses a multi-cycle restoring divider. It flags overflow and divide-by-zero, holds each result for a programmable time, and stores results in a HIST_DEPTH circular history that can be browsed and chained.

## Interface
- W, 16, operand/result width (unsigned), 8..32
- MAX_DIGITS, 4, max decimal digits accepted per operand
- HIST_DEPTH, 8, history entries (power of two, ≥2)
- HOLD_CYCLES, 2000, cycles the result is held in SHOW
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_en  in  1  one-cycle strobe: key is valid
- key  in  4  0-9 digit, A add, B sub, C mul, D div, E mod, F clear-entry
- equal  in  1  one-cycle strobe: execute
- hist_up / hist_down  in  1  one-cycle strobes: browse history (older/newer)
- out  out  W  display value
- busy  out  1  high in EXEC
- error  out  1  high in ERR
- res_valid  out  1  one-cycle pulse when a good result is written to history

## Operation
- States: IDLE, NUM1, NUM2, EXEC, SHOW, ERR.
- IDLE:
  - digit d → num1=d, go to NUM1.
  - Operator key → num1=out (chaining), op latched, num2=0, go to NUM2.
  - F → clears history read pointer to newest.
- NUM1:
  - digit → num1=num1*10+d.
  - Operator → latch op, num2=0, go to NUM2.
  - F → num1=0.
- NUM2:
  - digit → num2=num2*10+d.
  - Operator key → replaces op (last wins).
  - equal → EXEC.
  - F → num2=0.
- Digit limit: a digit is ignored if the operand already has MAX_DIGITS digits or if value*10+d > 2^W-1.
  - Leading zeros count as digits.
- EXEC:
  - add/sub/mul: 1 cycle.
  - div/mod: restoring divider, exactly W cycles.
- Errors (go to ERR instead of SHOW):
  - add carry out of W bits.
  - sub num1<num2.
  - mul product ≥ 2^W.
  - div/mod with num2=0: detected in the first EXEC cycle, no iteration.
- SHOW:
  - On entry: result written to history at wr_ptr, wr_ptr++ (wraps), count saturates at HIST_DEPTH; the oldest entry is overwritten when full.
  - res_valid pulses on that entry cycle. Read pointer reset to newest.
  - After HOLD_CYCLES → IDLE.
  - Any key_en during SHOW exits early to IDLE and is processed as an IDLE key in the same cycle.
- ERR: out=0, error=1, held until any key_en or equal, then → IDLE.
  - The key is consumed, not processed. History unchanged.
- History browse, in IDLE only:
  - hist_up → rd_ptr steps to older; saturates at oldest valid entry.
  - hist_down → steps newer; saturates at newest.
  - Both high at once → no move. Ignored in other states.
- out:
  - IDLE: history[rd_ptr], or 0 if history is empty.
  - NUM1: num1.
  - NUM2: num2.
  - EXEC: num1.
  - SHOW: result.
  - ERR: 0.
- Priority within a cycle: key_en > equal > hist_up/hist_down.
  - equal outside NUM2/ERR is ignored.
  - key_en and equal together in NUM2: key processed, equal dropped.
  - Inputs other than rst are ignored in EXEC (busy=1).

## Timing
- All outputs registered.
- Reset values: out=0, busy=0, error=0, res_valid=0, state IDLE, num1=num2=0, op=add, history empty, pointers 0, hold counter 0.
- Reset mid-EXEC or mid-SHOW aborts immediately; nothing is written to history.
- Latency, equal sampled at edge N:
  - EXEC at N+1.
  - add/sub/mul: SHOW at N+2, out=result at N+2.
  - div/mod: SHOW at N+1+W.
  - Divide-by-zero: ERR at N+2.
- SHOW lasts exactly HOLD_CYCLES cycles when undisturbed; IDLE on cycle HOLD_CYCLES+1 after entry.
- Digit/operator effects appear on out one cycle after the key_en edge.
- Hold counter and divider counters are sized with $clog2 of their bounds.

## Test plan
- Entry and add: keys 1,2,A,3,4, equal → out=46 two cycles after equal. res_valid pulses once. After 2000 cycles state is IDLE and out=46 from history.
- Divider and mod: 100 D 7 equal → busy high for exactly 16 cycles, then out=14. Then 100 E 7 equal → out=2.
- Errors: 5 B 9 equal → error=1, out=0; any key clears it. 9 D 0 equal → ERR at N+2. 300 C 300 equal (W=16) → ERR. History count unchanged in all three cases.
- Digit limit and clear-entry: keys 6,5,5,3,6 → num1=6553, 5th digit ignored. F → out=0. Keys 7,0,0,0,0 → 7000.
- History wrap and browse: 10 results 1..10 (HIST_DEPTH=8). hist_up ×9 → out saturates at 3. hist_down ×9 → out=10.
- Chaining and reset: after result 46, press A 4 equal → out=50. Assert rst during a div EXEC → all outputs 0 next cycle and history empty.

Source files
------------

// File: rtl/calc_if.sv
// Keypad-side and display-side signals of the calculator engine.
// key_en, equal, hist_up and hist_down are single-cycle strobes with no ready
// path: the engine samples them on every edge and drops them where not applicable.
interface calc_if #(
  parameter int W = 16
);
  logic         key_en;
  logic [3:0]   key;
  logic         equal;
  logic         hist_up;
  logic         hist_down;
  logic [W-1:0] out;
  logic         busy;
  logic         error;
  logic         res_valid;
  logic [2:0]   dbg_state;

  modport master (
    output key_en, key, equal, hist_up, hist_down,
    input  out, busy, error, res_valid, dbg_state
  );

  modport slave (
    input  key_en, key, equal, hist_up, hist_down,
    output out, busy, error, res_valid, dbg_state
  );
endinterface

// File: rtl/calc_core.sv
// Four-function unsigned calculator: decimal entry, 1-cycle add/sub/mul,
// W-cycle restoring divide/mod, timed result display and a browsable circular history.
module calc_core #(
  parameter int W           = 16,
  parameter int MAX_DIGITS  = 4,
  parameter int HIST_DEPTH  = 8,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic  clk,
  input  logic  rst,
  calc_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(W);
  localparam int PW = $clog2(HIST_DEPTH);
  localparam int NW = $clog2(HIST_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM1 = 3'd1,
    S_NUM2 = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_t;

  state_t        state, state_nxt;
  op_t           op, op_nxt;
  logic [W-1:0]  num1, num1_nxt, num2, num2_nxt;
  logic [CW-1:0] cnt1, cnt1_nxt, cnt2, cnt2_nxt;
  logic [W-1:0]  rem, rem_nxt, quo, quo_nxt;
  logic [W-1:0]  result, result_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [W-1:0]  hist [HIST_DEPTH];
  logic [PW-1:0] wr_ptr, rd_age, rd_age_nxt, rd_idx;
  logic [NW-1:0] hist_cnt;
  logic          hist_we;
  logic [W-1:0]  out_q, out_nxt;
  logic          busy_q, error_q, res_valid_q, res_valid_nxt;

  logic          is_digit, is_op, is_clr;
  op_t           key_op;
  logic [W+3:0]  app1, app2;
  logic          ok1, ok2;
  logic [W:0]    sum, trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]  rem_step, quo_step;
  logic          idle_key, show, fault;
  logic [W-1:0]  res;

  assign is_digit = (bus.key <= 4'd9);
  assign is_op    = (bus.key >= 4'hA) && (bus.key <= 4'hE);
  assign is_clr   = (bus.key == 4'hF);
  assign key_op   = op_t'(bus.key[2:0] - 3'd2);

  // value*10 + d computed 4 bits wider so the overflow test is exact
  assign app1 = ({4'd0, num1} << 3) + ({4'd0, num1} << 1) + {{W{1'b0}}, bus.key};
  assign app2 = ({4'd0, num2} << 3) + ({4'd0, num2} << 1) + {{W{1'b0}}, bus.key};
  assign ok1  = (cnt1 < CW'(MAX_DIGITS)) && (app1[W+3:W] == 4'd0);
  assign ok2  = (cnt2 < CW'(MAX_DIGITS)) && (app2[W+3:W] == 4'd0);

  assign sum   = {1'b0, num1} + {1'b0, num2};
  assign prod  = {{W{1'b0}}, num1} * {{W{1'b0}}, num2};
  // one restoring step: shift in the next dividend bit, subtract if it fits
  assign trial    = {rem, quo[W-1]} - {1'b0, num2};
  assign rem_step = trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
  assign quo_step = {quo[W-2:0], ~trial[W]};

  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    num1_nxt      = num1;
    num2_nxt      = num2;
    cnt1_nxt      = cnt1;
    cnt2_nxt      = cnt2;
    rem_nxt       = rem;
    quo_nxt       = quo;
    div_cnt_nxt   = div_cnt;
    result_nxt    = result;
    hold_nxt      = hold_cnt;
    rd_age_nxt    = rd_age;
    hist_we       = 1'b0;
    res_valid_nxt = 1'b0;
    idle_key      = 1'b0;
    show          = 1'b0;
    fault         = 1'b0;
    res           = '0;

    case (state)
      S_IDLE: begin
        if (bus.key_en) begin
          idle_key = 1'b1;
        end else if (bus.hist_up && !bus.hist_down) begin
          if (NW'(rd_age) + NW'(1) < hist_cnt) rd_age_nxt = rd_age + PW'(1);
        end else if (bus.hist_down && !bus.hist_up) begin
          if (rd_age != '0) rd_age_nxt = rd_age - PW'(1);
        end
      end
      S_NUM1: begin
        if (bus.key_en) begin
          if (is_digit) begin
            if (ok1) begin
              num1_nxt = app1[W-1:0];
              cnt1_nxt = cnt1 + CW'(1);
            end
          end else if (is_op) begin
            op_nxt    = key_op;
            num2_nxt  = '0;
            cnt2_nxt  = '0;
            state_nxt = S_NUM2;
          end else begin
            num1_nxt = '0;
            cnt1_nxt = '0;
          end
        end
      end
      S_NUM2: begin
        if (bus.key_en) begin
          if (is_digit) begin
            if (ok2) begin
              num2_nxt = app2[W-1:0];
              cnt2_nxt = cnt2 + CW'(1);
            end
          end else if (is_op) begin
            op_nxt = key_op;
          end else if (is_clr) begin
            num2_nxt = '0;
            cnt2_nxt = '0;
          end
        end else if (bus.equal) begin
          state_nxt   = S_EXEC;
          rem_nxt     = '0;
          quo_nxt     = num1;
          div_cnt_nxt = '0;
        end
      end
      S_EXEC: begin
        if (op == OP_DIV || op == OP_MOD) begin
          if (num2 == '0) begin
            state_nxt = S_ERR;
          end else begin
            rem_nxt     = rem_step;
            quo_nxt     = quo_step;
            div_cnt_nxt = div_cnt + DW'(1);
            if (div_cnt == DW'(W - 1)) begin
              show = 1'b1;
              res  = (op == OP_DIV) ? quo_step : rem_step;
            end
          end
        end else begin
          if (op == OP_ADD) begin
            res   = sum[W-1:0];
            fault = sum[W];
          end else if (op == OP_SUB) begin
            res   = num1 - num2;
            fault = (num1 < num2);
          end else begin
            res   = prod[W-1:0];
            fault = |prod[2*W-1:W];
          end
          if (fault) state_nxt = S_ERR;
          else       show      = 1'b1;
        end
      end
      S_SHOW: begin
        if (bus.key_en) begin
          idle_key = 1'b1;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      S_ERR: begin
        if (bus.key_en || bus.equal) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // IDLE key handling, shared with the early exit out of SHOW
    if (idle_key) begin
      state_nxt = S_IDLE;
      if (is_digit) begin
        num1_nxt  = {{(W-4){1'b0}}, bus.key};
        cnt1_nxt  = CW'(1);
        state_nxt = S_NUM1;
      end else if (is_op) begin
        num1_nxt  = out_q;
        op_nxt    = key_op;
        num2_nxt  = '0;
        cnt2_nxt  = '0;
        state_nxt = S_NUM2;
      end else begin
        rd_age_nxt = '0;
      end
    end

    if (show) begin
      state_nxt     = S_SHOW;
      result_nxt    = res;
      hist_we       = 1'b1;
      res_valid_nxt = 1'b1;
      hold_nxt      = '0;
      rd_age_nxt    = '0;
    end

    rd_idx = wr_ptr - PW'(1) - rd_age_nxt;
    case (state_nxt)
      S_IDLE:  out_nxt = (hist_cnt == '0) ? '0 : hist[rd_idx];
      S_NUM1:  out_nxt = num1_nxt;
      S_NUM2:  out_nxt = num2_nxt;
      S_EXEC:  out_nxt = num1_nxt;
      S_SHOW:  out_nxt = result_nxt;
      default: out_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= OP_ADD;
      num1        <= '0;
      num2        <= '0;
      cnt1        <= '0;
      cnt2        <= '0;
      rem         <= '0;
      quo         <= '0;
      div_cnt     <= '0;
      result      <= '0;
      hold_cnt    <= '0;
      rd_age      <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      op          <= op_nxt;
      num1        <= num1_nxt;
      num2        <= num2_nxt;
      cnt1        <= cnt1_nxt;
      cnt2        <= cnt2_nxt;
      rem         <= rem_nxt;
      quo         <= quo_nxt;
      div_cnt     <= div_cnt_nxt;
      result      <= result_nxt;
      hold_cnt    <= hold_nxt;
      rd_age      <= rd_age_nxt;
      out_q       <= out_nxt;
      busy_q      <= (state_nxt == S_EXEC);
      error_q     <= (state_nxt == S_ERR);
      res_valid_q <= res_valid_nxt;
    end
  end

  // circular history: oldest entry is overwritten once full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      wr_ptr   <= '0;
      hist_cnt <= '0;
    end else if (hist_we) begin
      hist[wr_ptr] <= result_nxt;
      wr_ptr       <= wr_ptr + PW'(1);
      if (hist_cnt != NW'(HIST_DEPTH)) hist_cnt <= hist_cnt + NW'(1);
    end
  end

  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
  assign bus.res_valid = res_valid_q;
  assign bus.dbg_state = state;
endmodule
